// File: rtl/spi_ctrl_pkg.sv
// Shared types for the SPI command sequencer: opcodes, FSM states, frame constants.
package spi_ctrl_pkg;

    typedef enum logic [7:0] {
        OP_WRITE = 8'h01,
        OP_READ  = 8'h02
    } spi_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_WDATA,
        ST_RFETCH,
        ST_RWAIT,
        ST_RSEND,
        ST_RGUARD
    } spi_ctrl_state_t;

    localparam int SPI_FRAME_HDR_BYTES = 3;

endpackage

// File: rtl/spi_idle_timer.sv
// Idle counter for partial-frame abort; emits a one-cycle expired pulse after
// TIMEOUT_CYCLES consecutive enabled cycles without a clear.
module spi_idle_timer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_L,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (clear || !enable) begin
                cnt <= '0;
            end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                cnt     <= '0;
                expired <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: parses opcode/addr/len/payload frames into memory writes
// and byte-streamed reads. Optional partial-frame timeout under SPI_CMD_TIMEOUT_EN.
module spi_cmd_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int AW             = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic          clk,
    input  logic          rst_L,
    input  logic [7:0]    byte_recv,
    input  logic          valid,
    input  logic          busy,
    output logic          write,
    output logic [7:0]    byte_send,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    output logic          mem_re,
    input  logic [7:0]    mem_rdata,
    output logic          frame_done,
    output logic          cmd_err
);

    spi_ctrl_state_t state;
    logic [7:0]      idx;
    logic [7:0]      len;
    logic [AW-1:0]   base;
    logic            is_read;
    logic            pend_vld;
    logic [7:0]      pend_byte;
    logic            tmo_expired;

    // A byte that lands on a timeout abort is parked and replayed as an opcode.
    logic       in_vld;
    logic [7:0] in_byte;
    assign in_vld  = valid | pend_vld;
    assign in_byte = pend_vld ? pend_byte : byte_recv;

    logic [AW-1:0] cur_addr;
    logic          last_byte;
    assign cur_addr  = base + AW'(idx);
    assign last_byte = (idx == len - 8'd1);

`ifdef SPI_CMD_TIMEOUT_EN
    logic tmo_en;
    assign tmo_en = (state == ST_ADDR) || (state == ST_LEN) || (state == ST_WDATA);

    spi_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
        .clk     (clk),
        .rst_L   (rst_L),
        .clear   (valid),
        .enable  (tmo_en),
        .expired (tmo_expired)
    );
`else
    logic unused_cfg;
    assign unused_cfg  = ^TIMEOUT_CYCLES;
    assign tmo_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state      <= ST_IDLE;
            idx        <= '0;
            len        <= '0;
            base       <= '0;
            is_read    <= 1'b0;
            pend_vld   <= 1'b0;
            pend_byte  <= '0;
            write      <= 1'b0;
            byte_send  <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            mem_re     <= 1'b0;
            frame_done <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            write      <= 1'b0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            frame_done <= 1'b0;
            cmd_err    <= 1'b0;
            pend_vld   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_vld) begin
                        idx <= '0;
                        if (in_byte == OP_WRITE || in_byte == OP_READ) begin
                            is_read <= (in_byte == OP_READ);
                            state   <= ST_ADDR;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                ST_ADDR, ST_LEN, ST_WDATA: begin
                    if (tmo_expired) begin
                        cmd_err   <= 1'b1;
                        state     <= ST_IDLE;
                        pend_vld  <= valid;
                        pend_byte <= byte_recv;
                    end else if (in_vld) begin
                        case (state)
                            ST_ADDR: begin
                                base  <= AW'(in_byte);
                                state <= ST_LEN;
                            end
                            ST_LEN: begin
                                len <= in_byte;
                                idx <= '0;
                                if (in_byte == 8'd0) begin
                                    frame_done <= 1'b1;
                                    state      <= ST_IDLE;
                                end else if (is_read) begin
                                    // Fetch issued here so rdata lands while in RWAIT.
                                    mem_re   <= 1'b1;
                                    mem_addr <= base;
                                    state    <= ST_RFETCH;
                                end else begin
                                    state <= ST_WDATA;
                                end
                            end
                            ST_WDATA: begin
                                mem_we    <= 1'b1;
                                mem_addr  <= cur_addr;
                                mem_wdata <= in_byte;
                                idx       <= idx + 8'd1;
                                if (last_byte) begin
                                    frame_done <= 1'b1;
                                    state      <= ST_IDLE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RFETCH: state <= ST_RWAIT;
                ST_RWAIT: begin
                    byte_send <= mem_rdata;
                    state     <= ST_RSEND;
                end
                ST_RSEND: begin
                    if (!busy) begin
                        write <= 1'b1;
                        state <= ST_RGUARD;
                    end
                end
                ST_RGUARD: begin
                    idx <= idx + 8'd1;
                    if (last_byte) begin
                        frame_done <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        mem_re   <= 1'b1;
                        mem_addr <= cur_addr + AW'(1);
                        state    <= ST_RFETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_cmd_ctrl.md
# spi_cmd_ctrl

Command sequencer on the FPGA side of the SPI slave (`spi_module`). It parses byte frames from the receive path (`byte_recv`/`valid`) into register-file writes and reads. For reads it streams data back through the transmit path (`byte_send`/`write`/`busy`), one byte at a time. It is the only master of the SPI transmit handshake and of the local memory port.

## Interface
- `AW`, 8: memory address width; the frame address byte is zero-extended or truncated to `AW`.
- `TIMEOUT_CYCLES`, 4096: idle cycles before a partial frame is aborted (only with `SPI_CMD_TIMEOUT_EN`).
- `clk` in 1: system clock; single clock domain.
- `rst_L` in 1: reset, asynchronous, active-low.
- `byte_recv` in 8: received byte; meaningful only when `valid`=1.
- `valid` in 1: one-cycle pulse per received byte.
- `busy` in 1: transmit path occupied.
- `write` out 1: one-cycle pulse that loads `byte_send` into the transmit path.
- `byte_send` out 8: byte to transmit; held stable from `write` until the next load.
- `mem_addr` out AW: memory address.
- `mem_we` out 1: write strobe, one cycle.
- `mem_wdata` out 8: write data.
- `mem_re` out 1: read strobe, one cycle.
- `mem_rdata` in 8: read data, valid exactly 1 cycle after `mem_re`.
- `frame_done` out 1: one-cycle pulse when a frame completes.
- `cmd_err` out 1: one-cycle pulse on a bad opcode or a timeout abort.

## Operation
- Frame format: opcode, address A, length N (0–255), then payload.
- Opcodes: 0x01 WRITE, 0x02 READ. Any other opcode pulses `cmd_err`, discards the byte and stays in IDLE.
- State machine transitions:
  - IDLE→ADDR on a valid opcode.
  - ADDR→LEN on the next `valid`.
  - LEN: if N=0, pulse `frame_done` and go to IDLE. Otherwise go to WDATA (WRITE) or RFETCH (READ).
  - WDATA: each `valid` byte i produces `mem_we`=1, `mem_addr`=(A+i) mod 2^AW, `mem_wdata`=byte, all in the cycle after `valid`. After byte N-1, pulse `frame_done` and go to IDLE.
  - RFETCH: pulse `mem_re` with addr (A+i) mod 2^AW, then go to RWAIT.
  - RWAIT: capture `mem_rdata` into `byte_send`, then go to RSEND.
  - RSEND: if `busy`=0, pulse `write` and go to RGUARD.
  - RGUARD: one cycle with `busy` ignored. Then i++; if i==N, pulse `frame_done` and go to IDLE, else go to RFETCH.
- Bytes received while the block is in RFETCH, RWAIT, RSEND or RGUARD are master dummy clocks and are ignored.
- Address wraps modulo 2^AW; it never saturates.
- `write` is never asserted while `busy`=1, and never in two consecutive cycles.
- `mem_we` and `mem_re` are never asserted in the same cycle.

## Timing
- Reset values:
  - All outputs are 0; `byte_send`=0x00.
  - State=IDLE; counter i=0.
- Reset asserted mid-frame returns the block to IDLE asynchronously. Any partial write already issued stays in memory.
- Write latency: `mem_we` is asserted 1 cycle after the payload `valid`.
- Read latency:
  - First `write` is asserted at least 3 cycles after the LEN byte's `valid` (RFETCH, RWAIT, RSEND), and later if `busy` is high.
  - Per-byte loop is at least 4 cycles.
- `frame_done` and `cmd_err` are never asserted together.
- A `valid` arriving in the same cycle as a timeout abort is treated as a new opcode in IDLE on the following cycle; it is not lost, because the byte is registered.

## Configuration
- `SPI_CMD_TIMEOUT_EN` defined:
  - An idle counter clears on every `valid` and on every state change.
  - It counts while the state is ADDR, LEN or WDATA.
  - On reaching `TIMEOUT_CYCLES`, the block pulses `cmd_err` and returns to IDLE.
  - READ states are exempt, because forward progress there is gated by `busy`.
- `SPI_CMD_TIMEOUT_EN` undefined:
  - No counter exists.
  - A partial frame waits indefinitely; only reset recovers it.

## Structure
- Package `spi_ctrl_pkg` holds:
  - opcode enum `spi_op_t` (OP_WRITE=8'h01, OP_READ=8'h02);
  - state enum `spi_ctrl_state_t`;
  - constant `SPI_FRAME_HDR_BYTES`=3.
- Sub-module `spi_idle_timer` holds the timeout counter (inputs: `clear`, `enable`; output: `expired` pulse). It is instantiated only under `SPI_CMD_TIMEOUT_EN`.

## Test plan
- WRITE 0x01,0x10,0x03,0xAA,0xBB,0xCC → `mem_we` at addr 0x10/0x11/0x12 with data AA/BB/CC; one `frame_done`; no `write`.
- Preload mem[0xFE]=0x11 and mem[0xFF]=0x22, mem[0x00]=0x33; send READ 0x02,0xFE,0x03 with `busy` tied 0 → `byte_send` takes 0x11, 0x22, 0x33 in that order (wrap), 3 `write` pulses at least 4 cycles apart, then `frame_done`.
- READ of 2 bytes with `busy` held high 20 cycles after the first `write` → second `write` is asserted only after `busy` falls; it never overlaps `busy`=1.
- Opcode 0x7F, then 0x01,0x00,0x00 → `cmd_err` on the first byte; `frame_done` after the LEN byte; no memory access.
- Send 0x01,0x20 then silence with `SPI_CMD_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16 → `cmd_err` after 16 idle cycles; a following valid frame executes normally.
- Assert `rst_L` low during WDATA after 1 of 4 bytes → all outputs 0 immediately; the next frame parses from IDLE.
